sa_result_drain: RTL

Output-side companion of the 8-bit systolic-array wrapper. It captures the wide result bus (X_R rows × 64 columns of signed Q2.5 bytes), presented for one cycle with its valid strobe, into a local buffer. It then streams the matrix out row-major as narrow beats over a valid/ready handshake toward the write-back/DDR path, so downstream logic never has to accept the full X_R×64×8-bit bus in a single cycle.

---
 rtl/sa_result_drain.sv | 92 +++++++++
 1 files changed

// File: rtl/sa_result_drain.sv
// Result-bus drain: captures one X_R x COLS matrix on a strobe and streams it
// out row-major as LANES-element beats over a valid/ready handshake.
module sa_result_drain #(
    parameter int  X_R    = 2,
    parameter int  COLS   = 64,
    parameter int  DW     = 8,
    parameter int  LANES  = 8,
    localparam int NBEATS = X_R * COLS / LANES,
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic                      I_CLK,
    input  logic                      I_RST,
    input  logic                      I_OUT_VLD,
    input  logic [X_R*COLS*DW-1:0]    I_OUT,
    input  logic                      I_RDY,
    input  logic                      I_CLR_OVF,
    output logic                      O_VLD,
    output logic [LANES*DW-1:0]       O_DATA,
    output logic [BEAT_W-1:0]         O_BEAT,
    output logic                      O_LAST,
    output logic                      O_BUSY,
    output logic                      O_DONE,
    output logic                      O_OVF
);

    localparam int BEAT_BITS = LANES * DW;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state_q;
    logic [BEAT_W-1:0]      beat_q;
    logic                   done_q;
    logic                   ovf_q;
    logic [BEAT_BITS-1:0]   buf_q [NBEATS];
    logic                   last_beat;

    assign last_beat = (beat_q == BEAT_W'(NBEATS - 1));

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q <= IDLE;
            beat_q  <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // A strobe that lands while draining is dropped; setting beats clearing.
            if (I_OUT_VLD && (state_q == SEND))
                ovf_q <= 1'b1;
            else if (I_CLR_OVF)
                ovf_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (I_OUT_VLD) begin
                        state_q <= SEND;
                        beat_q  <= '0;
                    end
                end
                SEND: begin
                    if (I_RDY) begin
                        if (last_beat) begin
                            state_q <= IDLE;
                            beat_q  <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Data buffer is deliberately left out of reset; outputs are gated by state instead.
    always_ff @(posedge I_CLK) begin
        if ((state_q == IDLE) && I_OUT_VLD) begin
            for (int k = 0; k < NBEATS; k++)
                buf_q[k] <= I_OUT[k*BEAT_BITS +: BEAT_BITS];
        end
    end

    assign O_VLD  = (state_q == SEND);
    assign O_BUSY = (state_q == SEND);
    assign O_DATA = (state_q == SEND) ? buf_q[beat_q] : '0;
    assign O_BEAT = beat_q;
    assign O_LAST = (state_q == SEND) && last_beat;
    assign O_DONE = done_q;
    assign O_OVF  = ovf_q;

endmodule
